axi4_lite_req_arbiter: RTL and testbench
========================================

// Module: axi4_lite_req_arbiter
// PURPOSE
//  Shares one AXI4-Lite master port among N_REQ local requesters (core, DMA, debug).
//  Picks one pending request round-robin and sequences the master through one
//  transaction: a one-cycle start_write/start_read pulse, then a wait for write_done/read_done.
//  Returns read data and a one-cycle ack to the winner.
//  Sits between the requesters and axi4_lite_master. Only one transaction is outstanding at a time.
// PARAMETERS
//  N_REQ    4    number of requesters (2..8)
//  ADDR_W   32   address width
//  DATA_W   32   data width
//  TIMEOUT  255  max WAIT cycles before error completion; 0 = no timeout
// PORTS
//  clk              in   1              clock, rising edge
//  rst              in   1              asynchronous, active-high reset
//  req              in   N_REQ          request pending, held until ack
//  req_we           in   N_REQ          1 = write, 0 = read
//  req_addr         in   N_REQ*ADDR_W   per-requester address, slice i
//  req_wdata        in   N_REQ*DATA_W   per-requester write data, slice i
//  ack              out  N_REQ          one-cycle completion pulse to the granted requester
//  rsp_rdata        out  DATA_W         read data, valid while any ack bit = 1
//  rsp_err          out  1              timeout flag, valid while any ack bit = 1
//  busy             out  1              high in every state except IDLE
//  m_start_write    out  1              to master start_write
//  m_start_read     out  1              to master start_read
//  m_write_address  out  ADDR_W         to master write_address
//  m_write_data     out  DATA_W         to master write_data
//  m_read_address   out  ADDR_W         to master read_address
//  m_read_data      in   DATA_W         from master read_data
//  m_write_done     in   1              from master, one-cycle pulse
//  m_read_done      in   1              from master, one-cycle pulse
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; rr pointer = N_REQ-1 (requester 0 wins first).
//  FSM
//   IDLE  -> ISSUE when |req.
//           Grant goes to the first set bit searching ptr+1, ptr+2, ... modulo N_REQ.
//           On that edge, latch grant index, we, addr and wdata.
//   ISSUE -> WAIT unconditionally.
//           Exactly one of m_start_write / m_start_read is high, for exactly this cycle.
//   WAIT  -> DONE on the done pulse matching the latched we; that done is in DONE/IDLE,
//           ignored. Read: capture m_read_data on the same edge.
//           If TIMEOUT != 0 and the wait counter reaches TIMEOUT: -> DONE with err = 1.
//   DONE  -> IDLE unconditionally. ack[grant] = 1, rsp_rdata/rsp_err driven, ptr <= grant.
//  Address and data outputs are registered.
//   They hold the latched values from ISSUE until the next grant, then are stable.
//   The master samples them while it sits in its ADDR and DATA states.
//  Latency, req high in IDLE at cycle 0:
//   - start pulse at cycle 1
//   - ack at cycle k+1, where k is the done-pulse cycle
//  A done pulse that does not match the latched we is ignored.
//   So is any done pulse in IDLE, ISSUE or DONE.
//  req dropped mid-transaction: the transaction still completes and ack still pulses.
//  rsp_rdata = 0 for writes and for timed-out reads. rsp_err = 0 except on timeout.
//  Wait counter is clog2(TIMEOUT+1) bits, cleared in ISSUE, saturating.
//  A late done after a timeout arrives while in IDLE/ISSUE/DONE and is ignored.
//  rst asserted mid-transaction:
//   - FSM returns to IDLE and the pointer is reset
//   - no ack is issued
//   - master and requesters are reset by the same rst
// STRUCTURE
//  axi_lite_arb_pkg: arb_state_t {IDLE, ISSUE, WAIT, DONE}; function rr_pick(req, ptr)
//  returning a one-hot grant.
//  Sub-module rr_arbiter #(N_REQ): combinational pick of req and ptr, giving grant_oh,
//  grant_idx and any.
//  Top level holds the FSM, latches, wait counter and ack/response registers.
// TESTING (bench pairs it with axi4_lite_master and a memory slave model)
//  1. req[0] write, addr 0x10, data 0xDEADBEEF.
//     -> m_start_write one cycle; ack[0] one cycle after write_done; later read of 0x10
//        returns 0xDEADBEEF with rsp_err = 0.
//  2. req = 4'b1111 held, all reads.
//     -> ack order 0, 1, 2, 3, 0; never two acks in the same cycle; busy low for one cycle
//        between grants.
//  3. req[2] read while a requester-1 write is in flight.
//     -> req[2] is granted only after ack[1]; rsp_rdata matches memory for addr_2.
//  4. Slave never responds, TIMEOUT = 8.
//     -> ack with rsp_err = 1 exactly 9 cycles after the start pulse; rsp_rdata = 0.
//  5. Spurious m_read_done pulsed during a write WAIT.
//     -> ignored; completion occurs only on m_write_done.
//  6. rst pulsed in WAIT.
//     -> all outputs 0 the same cycle; next grant goes to requester 0; no stale ack.

Source files
------------

// File: rtl/axi_lite_arb_pkg.sv
// Shared types and the round-robin pick used by the AXI4-Lite request arbiter.
// State constants stay plain localparams so legacy tools see a simple 2-bit code.
package axi_lite_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t ISSUE = 2'd1;
    localparam arb_state_t WAIT  = 2'd2;
    localparam arb_state_t DONE  = 2'd3;

    localparam int MAX_REQ = 8;

    // One-hot grant: first set bit searching ptr+1, ptr+2, ... modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                    input logic [2:0]         ptr,
                                                    input int                 n);
        logic [MAX_REQ-1:0] grant;
        logic [2:0]         idx;
        grant = '0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = 3'((int'(ptr) + i) % n);
            if (i <= n && grant == '0 && req[idx]) grant[idx] = 1'b1;
        end
        return grant;
    endfunction

endpackage

// File: rtl/axi4_lite_req_arbiter_if.sv
// Requester-side and master-side signals of the request arbiter.
// The master modport is the arbiter's view; the slave modport is its surroundings.
interface axi4_lite_req_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_err;
    logic                    busy;
    logic                    m_start_write;
    logic                    m_start_read;
    logic [ADDR_W-1:0]       m_write_address;
    logic [DATA_W-1:0]       m_write_data;
    logic [ADDR_W-1:0]       m_read_address;
    logic [DATA_W-1:0]       m_read_data;
    logic                    m_write_done;
    logic                    m_read_done;

    modport master (
        input  req, req_we, req_addr, req_wdata,
        input  m_read_data, m_write_done, m_read_done,
        output ack, rsp_rdata, rsp_err, busy,
        output m_start_write, m_start_read, m_write_address, m_write_data, m_read_address
    );

    modport slave (
        output req, req_we, req_addr, req_wdata,
        output m_read_data, m_write_done, m_read_done,
        input  ack, rsp_rdata, rsp_err, busy,
        input  m_start_write, m_start_read, m_write_address, m_write_data, m_read_address
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the requester after ptr that is pending wins.
module rr_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [MAX_REQ-1:0] req_wide;
    logic [MAX_REQ-1:0] pick;

    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        req_wide             = '0;
        req_wide[N_REQ-1:0]  = req;
        pick                 = rr_pick(req_wide, 3'(ptr), N_REQ);
        grant_oh             = pick[N_REQ-1:0];
        any                  = |pick;
        grant_idx            = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) grant_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Shares one AXI4-Lite master among N_REQ requesters, one transaction at a time:
// grant round-robin, pulse start, wait for the matching done (or timeout), then ack.
module axi4_lite_req_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic                       clk,
    input logic                       rst,
    axi4_lite_req_arbiter_if.master   bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t        state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              start_w_q;
    logic              start_r_q;
    logic [N_REQ-1:0]  ack_q;
    logic [CNT_W-1:0]  wait_cnt_q;

    logic [N_REQ-1:0]  grant_oh;
    logic [IDX_W-1:0]  grant_idx;
    logic              any_req;
    logic              done_hit;
    logic              timeout_hit;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req       (bus.req),
        .ptr       (ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    // Only the done that matches the latched direction completes the wait.
    always_comb begin
        done_hit    = we_q ? bus.m_write_done : bus.m_read_done;
        timeout_hit = (TIMEOUT != 0) && (int'(wait_cnt_q) + 1 == TIMEOUT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= IDX_W'(N_REQ - 1);
            grant_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            start_w_q  <= 1'b0;
            start_r_q  <= 1'b0;
            ack_q      <= '0;
            wait_cnt_q <= '0;
        end else begin
            start_w_q <= 1'b0;
            start_r_q <= 1'b0;
            ack_q     <= '0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q   <= ISSUE;
                        grant_q   <= grant_idx;
                        we_q      <= |(grant_oh & bus.req_we);
                        addr_q    <= bus.req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
                        wdata_q   <= bus.req_wdata[int'(grant_idx) * DATA_W +: DATA_W];
                        start_w_q <= |(grant_oh & bus.req_we);
                        start_r_q <= ~|(grant_oh & bus.req_we);
                    end
                end
                ISSUE: begin
                    state_q    <= WAIT;
                    wait_cnt_q <= '0;
                end
                WAIT: begin
                    if (done_hit) begin
                        state_q <= DONE;
                        ack_q   <= N_REQ'(1) << grant_q;
                        rdata_q <= we_q ? '0 : bus.m_read_data;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q <= DONE;
                        ack_q   <= N_REQ'(1) << grant_q;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ptr_q   <= grant_q;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack             = ack_q;
    assign bus.rsp_rdata       = rdata_q;
    assign bus.rsp_err         = err_q;
    assign bus.busy            = (state_q != IDLE);
    assign bus.m_start_write   = start_w_q;
    assign bus.m_start_read    = start_r_q;
    assign bus.m_write_address = addr_q;
    assign bus.m_read_address  = addr_q;
    assign bus.m_write_data    = wdata_q;

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Directed bench: a memory slave with programmable latency, a transaction-level
// reference model checked every cycle, and hand-computed literal expectations.
module tb_axi4_lite_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_lite_req_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus_if ();

    axi4_lite_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory slave with latency, mute and spurious read_done
    int  lat     = 3;
    bit  mute    = 1'b0;
    bit  spur_rd = 1'b0;
    int  s_cnt   = 0;
    bit  s_we    = 1'b0;
    bit  s_init  = 1'b0;
    logic [31:0] mem [0:15];

    always @(negedge clk) begin
        if (!s_init) begin
            for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
            s_init = 1'b1;
        end
        bus_if.m_write_done = 1'b0;
        bus_if.m_read_done  = spur_rd;
        bus_if.m_read_data  = '0;
        if (rst) begin
            s_cnt = 0;
        end else if (bus_if.m_start_write || bus_if.m_start_read) begin
            s_we = bus_if.m_start_write;
            if (!mute) s_cnt = lat;
        end else if (s_cnt > 0) begin
            s_cnt--;
            if (s_cnt == 0) begin
                if (s_we) begin
                    mem[bus_if.m_write_address[5:2]] = bus_if.m_write_data;
                    bus_if.m_write_done = 1'b1;
                end else begin
                    bus_if.m_read_data = mem[bus_if.m_read_address[5:2]];
                    bus_if.m_read_done = 1'b1;
                end
            end
        end
    end

    // ---------------- reference model: one transaction at a time, timed by its age
    int          cyc     = 0;
    bit          m_txn   = 1'b0;
    int          m_ptr   = N - 1;
    int          m_g     = 0;
    bit          m_we    = 1'b0;
    int          m_issue = 0;
    int          m_ack_c = -10;
    int          age;
    int          k;
    logic        exp_busy = 1'b0;
    logic        exp_sw   = 1'b0;
    logic        exp_sr   = 1'b0;
    logic [N-1:0] exp_ack = '0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_wdata = '0;

    always @(posedge clk) begin
        cyc++;
        exp_sw = 1'b0; exp_sr = 1'b0; exp_ack = '0; exp_rdata = '0; exp_err = 1'b0;
        if (rst) begin
            m_txn = 1'b0; m_ptr = N - 1; m_ack_c = -10;
            exp_busy = 1'b0; exp_addr = '0; exp_wdata = '0;
        end else if (m_txn) begin
            exp_busy = 1'b1;
            age = cyc - 1 - m_issue;
            if (age >= 1 && (m_we ? bus_if.m_write_done : bus_if.m_read_done)) begin
                exp_ack[m_g] = 1'b1;
                exp_rdata    = m_we ? 32'h0 : bus_if.m_read_data;
                m_txn = 1'b0; m_ack_c = cyc; m_ptr = m_g;
            end else if (TO != 0 && age == TO) begin
                exp_ack[m_g] = 1'b1;
                exp_err      = 1'b1;
                m_txn = 1'b0; m_ack_c = cyc; m_ptr = m_g;
            end
        end else if (m_ack_c == cyc - 1) begin
            exp_busy = 1'b0;
        end else if (|bus_if.req) begin
            m_g = -1;
            for (int i = 1; i <= N; i++) begin
                k = (m_ptr + i) % N;
                if (m_g < 0 && bus_if.req[k]) m_g = k;
            end
            m_we      = bus_if.req_we[m_g];
            exp_addr  = bus_if.req_addr[m_g*AW +: AW];
            exp_wdata = bus_if.req_wdata[m_g*DW +: DW];
            exp_sw    = m_we;
            exp_sr    = !m_we;
            exp_busy  = 1'b1;
            m_txn     = 1'b1;
            m_issue   = cyc;
        end else begin
            exp_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy",     bus_if.busy,            exp_busy);
            check("ack",      bus_if.ack,             exp_ack);
            check("start_wr", bus_if.m_start_write,   exp_sw);
            check("start_rd", bus_if.m_start_read,    exp_sr);
            check("waddr",    bus_if.m_write_address, exp_addr);
            check("raddr",    bus_if.m_read_address,  exp_addr);
            check("wdata",    bus_if.m_write_data,    exp_wdata);
            if (exp_ack != '0) begin
                check("rsp_rdata", bus_if.rsp_rdata, exp_rdata);
                check("rsp_err",   bus_if.rsp_err,   exp_err);
            end
        end
    end

    // ---------------- stimulus helpers (drive/sample 2 time units after the edge)
    task automatic set_req(input int i, input bit we, input logic [31:0] a, input logic [31:0] d);
        bus_if.req_we[i]             = we;
        bus_if.req_addr[i*AW +: AW]  = a;
        bus_if.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_start(output int s);
        s = -1;
        for (int n = 0; n < 64 && s < 0; n++) begin
            @(posedge clk); #2;
            if (bus_if.m_start_write || bus_if.m_start_read) s = cyc;
        end
        if (s < 0) check("start_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_ack(output int idx, output int c, output logic [31:0] rd, output logic er);
        idx = -1; c = -1; rd = '0; er = 1'b0;
        for (int n = 0; n < 64 && idx < 0; n++) begin
            @(posedge clk); #2;
            if (|bus_if.ack) begin
                for (int i = 0; i < N; i++) if (bus_if.ack[i]) idx = i;
                c  = cyc;
                rd = bus_if.rsp_rdata;
                er = bus_if.rsp_err;
            end
        end
        if (idx < 0) check("ack_timeout", 1'b0, 1'b1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        bus_if.req = '0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    int          s, c0, a_idx, a_cyc, prev_cyc;
    logic [31:0] a_rd;
    logic        a_er;
    int          order [5] = '{0, 1, 2, 3, 0};

    initial begin
        bus_if.req = '0; bus_if.req_we = '0; bus_if.req_addr = '0; bus_if.req_wdata = '0;

        // reset state
        @(posedge clk); #2;
        check("rst_busy",  bus_if.busy, 1'b0);
        check("rst_ack",   bus_if.ack, 4'b0000);
        check("rst_sw",    bus_if.m_start_write, 1'b0);
        check("rst_sr",    bus_if.m_start_read, 1'b0);
        check("rst_waddr", bus_if.m_write_address, 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;

        // 1: write 0x10 then read it back
        set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        bus_if.req = 4'b0001;
        c0 = cyc;
        wait_start(s);
        check("t1_start_lat", 32'(s - c0), 32'd1);
        wait_ack(a_idx, a_cyc, a_rd, a_er);
        bus_if.req = '0;
        check("t1_idx", 32'(a_idx), 32'd0);
        check("t1_ack_lat", 32'(a_cyc - s), 32'd4);
        check("t1_err", a_er, 1'b0);
        set_req(0, 1'b0, 32'h10, 32'h0);
        bus_if.req = 4'b0001;
        wait_ack(a_idx, a_cyc, a_rd, a_er);
        bus_if.req = '0;
        check("t1_rd_data", a_rd, 32'hDEAD_BEEF);
        check("t1_rd_err", a_er, 1'b0);

        // 2: all four read, held; fresh pointer
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'(4 * i), 32'h0);
        bus_if.req = 4'b1111;
        prev_cyc = 0;
        for (int n = 0; n < 5; n++) begin
            wait_ack(a_idx, a_cyc, a_rd, a_er);
            check("t2_order", 32'(a_idx), 32'(order[n]));
            check("t2_rdata", a_rd, 32'hC0DE_0000 + 32'(order[n]));
            if (n > 0) check("t2_spacing", 32'(a_cyc - prev_cyc), 32'd6);
            prev_cyc = a_cyc;
        end
        bus_if.req = '0;

        // 3: requester-2 read arrives while requester-1 write is in flight
        set_req(1, 1'b1, 32'h20, 32'h1234_5678);
        bus_if.req = 4'b0010;
        wait_start(s);
        set_req(2, 1'b0, 32'h20, 32'h0);
        bus_if.req = 4'b0110;
        wait_ack(a_idx, a_cyc, a_rd, a_er);
        bus_if.req = 4'b0100;
        check("t3_first", 32'(a_idx), 32'd1);
        wait_ack(a_idx, a_cyc, a_rd, a_er);
        bus_if.req = '0;
        check("t3_second", 32'(a_idx), 32'd2);
        check("t3_rdata", a_rd, 32'h1234_5678);

        // 4: silent slave -> timeout
        mute = 1'b1;
        set_req(3, 1'b0, 32'h30, 32'h0);
        bus_if.req = 4'b1000;
        wait_start(s);
        wait_ack(a_idx, a_cyc, a_rd, a_er);
        bus_if.req = '0;
        mute = 1'b0;
        check("t4_idx", 32'(a_idx), 32'd3);
        check("t4_lat", 32'(a_cyc - s), 32'd9);
        check("t4_err", a_er, 1'b1);
        check("t4_rdata", a_rd, 32'h0);

        // 5: spurious read_done during a write wait
        lat = 4;
        set_req(0, 1'b1, 32'h14, 32'hA5A5_A5A5);
        bus_if.req = 4'b0001;
        wait_start(s);
        @(posedge clk); #2; spur_rd = 1'b1;
        @(posedge clk); #2; spur_rd = 1'b0;
        wait_ack(a_idx, a_cyc, a_rd, a_er);
        bus_if.req = '0;
        check("t5_idx", 32'(a_idx), 32'd0);
        check("t5_lat", 32'(a_cyc - s), 32'd5);
        check("t5_err", a_er, 1'b0);
        lat = 3;

        // 6: reset while waiting
        set_req(1, 1'b0, 32'h0, 32'h0);
        bus_if.req = 4'b0010;
        wait_start(s);
        @(posedge clk); #2;
        rst = 1'b1;
        bus_if.req = '0;
        #1;
        check("t6_busy",  bus_if.busy, 1'b0);
        check("t6_ack",   bus_if.ack, 4'b0000);
        check("t6_sw",    bus_if.m_start_write, 1'b0);
        check("t6_sr",    bus_if.m_start_read, 1'b0);
        check("t6_raddr", bus_if.m_read_address, 32'h0);
        check("t6_wdata", bus_if.m_write_data, 32'h0);
        check("t6_rdata", bus_if.rsp_rdata, 32'h0);
        check("t6_err",   bus_if.rsp_err, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 32'(4 * i), 32'h0);
        bus_if.req = 4'b0111;
        wait_ack(a_idx, a_cyc, a_rd, a_er);
        bus_if.req = '0;
        check("t6_next_grant", 32'(a_idx), 32'd0);

        repeat (4) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
